stream_fifo_arbiter: RTL and testbench
======================================

# stream_fifo_arbiter

Round-robin, packet-locked arbiter that shares one downstream 8-bit StreamingFIFO between NUM_SRC AXI-stream producers. It grants one producer at a time for exactly PKT_LEN beats. It also throttles new grants using the FIFO occupancy (`count`) fed back from the FIFO. It sits directly in front of the shared FIFO's `in0_V` port, and its `out_src` sideband identifies the owner of each beat.

## Interface
- NUM_SRC, 4: number of producers (2..8).
- WIDTH, 8: TDATA width per stream.
- PKT_LEN, 16: beats per grant (2..256).
- CNT_W, 11: width of FIFO occupancy input.
- HIGH_WM, 1536: no new grant while fifo_count >= HIGH_WM.
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- in_V_TDATA  in  NUM_SRC*WIDTH  producer data; source i occupies bits [i*WIDTH +: WIDTH].
- in_V_TVALID  in  NUM_SRC  producer valid.
- in_V_TREADY  out  NUM_SRC  producer ready.
- out_V_TDATA  out  WIDTH  to FIFO in0_V_TDATA.
- out_V_TVALID  out  1  to FIFO in0_V_TVALID.
- out_V_TREADY  in  1  from FIFO in0_V_TREADY.
- out_src  out  clog2(NUM_SRC)  index of granted source.
- fifo_count  in  CNT_W  FIFO `count` output.
- grant  out  NUM_SRC  one-hot current owner; all-zero when idle.
- busy  out  1  high in LOCK state.
- stat_sel  in  clog2(NUM_SRC)  statistics source select.
- stat_pkts  out  16  packet count for stat_sel.

## Operation
- FSM has two states: IDLE and LOCK.
- **IDLE:**
  - grant=0, out_V_TVALID=0, in_V_TREADY=0.
  - If any in_V_TVALID is set and fifo_count < HIGH_WM, select the first valid source searching from last_src+1 upward, wrapping modulo NUM_SRC.
  - Register grant and out_src, clear beat_cnt, and go to LOCK.
- **LOCK:**
  - out_V_TDATA/out_V_TVALID pass combinationally from the granted source.
  - in_V_TREADY[g] = out_V_TREADY; all other TREADY bits are 0.
  - Each handshake (out_V_TVALID & out_V_TREADY) increments beat_cnt.
  - A handshake with beat_cnt == PKT_LEN-1 ends the packet: last_src <= g, go to IDLE.
- Grant is held for the full packet regardless of producer valid gaps. There is no timeout.
- The watermark is checked only at grant time. A packet in flight always completes, even if fifo_count crosses HIGH_WM.
- beat_cnt is clog2(PKT_LEN) bits wide and never wraps inside a packet.
- Reset values: state=IDLE, grant=0, out_src=0, busy=0, out_V_TVALID=0, in_V_TREADY=0, beat_cnt=0, last_src=NUM_SRC-1 (so source 0 wins first), stat counters 0.
- Reset mid-packet abandons the packet. No beats are emitted after the reset cycle.

## Timing
- Grant is visible one cycle after a valid source is seen in IDLE. The first beat can transfer in that same LOCK cycle.
- Data path latency is 0 cycles (combinational mux), with no registers between source and FIFO.
- Arbitration overhead is exactly one idle cycle per packet. Peak throughput is PKT_LEN/(PKT_LEN+1) beats/cycle.
- The return to IDLE takes effect the cycle after the final handshake. The rearbitration decision occurs in that IDLE cycle.
- fifo_count is sampled in the IDLE cycle only. The FIFO's own backpressure (out_V_TREADY) governs all in-packet flow.

## Configuration
- Macro: STREAM_FIFO_ARB_STATS_EN.
- **Defined:** one 16-bit counter per source, incremented on each completed packet and saturating at 0xFFFF. stat_pkts = counter[stat_sel], registered with 1-cycle latency.
- **Undefined:** no counters are built. stat_pkts is tied to 0. Ports remain present so instantiations are unchanged.

## Test plan
- **Single source:** src1 sends 16 beats continuously with out_V_TREADY=1 -> grant=0b0010 one cycle after TVALID; 16 beats out in 16 consecutive cycles with out_src=1; then grant=0.
- **Round-robin:** all 4 sources valid continuously after reset -> grants in order 0,1,2,3,0. Exactly one idle cycle between packets.
- **Watermark:** fifo_count=1536 with all sources valid -> grant stays 0. Drop fifo_count to 1535 -> grant issued next cycle. Raise fifo_count to 1600 mid-packet -> packet still completes 16 beats.
- **Backpressure/gaps:** toggle out_V_TREADY and the producer TVALID randomly during a packet -> exactly 16 handshakes, data order preserved, non-granted TREADY always 0.
- **Reset mid-packet:** assert ap_rst after beat 7 -> next cycle grant=0, out_V_TVALID=0. The next arbitration grants source 0 first.
- **Stats (macro defined):** 3 packets from src2 -> stat_sel=2 gives stat_pkts=3 one cycle later. Other sources read 0.

Source files
------------

// File: rtl/stream_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// stream_fifo_arbiter
//   Round-robin, packet-locked arbiter in front of a shared 8-bit
//   StreamingFIFO (in0_V). One producer owns the FIFO for exactly PKT_LEN
//   handshakes. New grants are withheld while the FIFO occupancy is at or
//   above HIGH_WM.
//
//   Optional macro STREAM_FIFO_ARB_STATS_EN adds a saturating 16-bit
//   per-source packet counter. The selected counter is read back on
//   stat_pkts one cycle after stat_sel. Without the macro, stat_pkts is 0.
//
// Ports
//   ap_clk, ap_rst         clock; synchronous active-high reset
//   in_V_TDATA/TVALID/TREADY  NUM_SRC producer streams (source i at [i*WIDTH +: WIDTH])
//   out_V_TDATA/TVALID/TREADY  merged stream to FIFO in0_V
//   out_src                index of the owning source
//   fifo_count             FIFO occupancy, sampled only when arbitrating
//   grant                  one-hot owner, zero while idle
//   busy                   high while a packet is locked
//   stat_sel, stat_pkts    packet-count readback
// ---------------------------------------------------------------------------

`ifdef STREAM_FIFO_ARB_STATS_EN
// Per-source saturating packet counter.
module stream_fifo_arbiter_pkt_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'd1;
    end
endmodule
`endif

module stream_fifo_arbiter #(
    parameter  int NUM_SRC = 4,
    parameter  int WIDTH   = 8,
    parameter  int PKT_LEN = 16,
    parameter  int CNT_W   = 11,
    parameter  int HIGH_WM = 1536,
    localparam int SRC_W   = $clog2(NUM_SRC),
    localparam int BEAT_W  = $clog2(PKT_LEN)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [NUM_SRC*WIDTH-1:0] in_V_TDATA,
    input  logic [NUM_SRC-1:0]       in_V_TVALID,
    output logic [NUM_SRC-1:0]       in_V_TREADY,
    output logic [WIDTH-1:0]         out_V_TDATA,
    output logic                     out_V_TVALID,
    input  logic                     out_V_TREADY,
    output logic [SRC_W-1:0]         out_src,
    input  logic [CNT_W-1:0]         fifo_count,
    output logic [NUM_SRC-1:0]       grant,
    output logic                     busy,
    input  logic [SRC_W-1:0]         stat_sel,
    output logic [15:0]              stat_pkts
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    state_t                         state_q, state_d;
    logic [NUM_SRC-1:0]             grant_q;
    logic [SRC_W-1:0]               out_src_q;
    logic [SRC_W-1:0]               last_src_q;
    logic [BEAT_W-1:0]              beat_q;
    logic [NUM_SRC-1:0][WIDTH-1:0]  in_data;
    logic [SRC_W-1:0]               pick;
    logic                           pick_vld;
    logic                           wm_ok;
    logic                           hs;
    logic                           pkt_end;

    assign in_data = in_V_TDATA;
    assign wm_ok   = int'(fifo_count) < HIGH_WM;

    // Round-robin pick: the valid source with the smallest forward distance
    // from last_src+1 (mod NUM_SRC) wins.
    always_comb begin
        int best;
        int d;
        best     = NUM_SRC;
        d        = 0;
        pick     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            d = (i + NUM_SRC - 1 - int'(last_src_q)) % NUM_SRC;
            if (in_V_TVALID[i] && d < best) begin
                best = d;
                pick = SRC_W'(i);
            end
        end
        pick_vld = best < NUM_SRC;
    end

    // Next state and combinational stream outputs.
    always_comb begin
        state_d      = state_q;
        out_V_TVALID = 1'b0;
        out_V_TDATA  = '0;
        in_V_TREADY  = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld && wm_ok)
                    state_d = LOCK;
            end
            LOCK: begin
                out_V_TVALID           = in_V_TVALID[out_src_q];
                out_V_TDATA            = in_data[out_src_q];
                in_V_TREADY[out_src_q] = out_V_TREADY;
                if (in_V_TVALID[out_src_q] && out_V_TREADY && beat_q == LAST_BEAT)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs      = (state_q == LOCK) && out_V_TVALID && out_V_TREADY;
    assign pkt_end = hs && (beat_q == LAST_BEAT);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            out_src_q  <= '0;
            beat_q     <= '0;
            last_src_q <= SRC_W'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == LOCK) begin
                grant_q   <= NUM_SRC'(1) << pick;
                out_src_q <= pick;
                beat_q    <= '0;
            end else if (hs) begin
                if (pkt_end) begin
                    grant_q    <= '0;
                    last_src_q <= out_src_q;
                    beat_q     <= '0;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
        end
    end

    assign grant   = grant_q;
    assign out_src = out_src_q;
    assign busy    = (state_q == LOCK);

`ifdef STREAM_FIFO_ARB_STATS_EN
    logic [NUM_SRC-1:0][15:0] pkt_cnt;
    logic [NUM_SRC-1:0]       pkt_done;
    logic [15:0]              stat_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_stat
        assign pkt_done[i] = pkt_end && (out_src_q == SRC_W'(i));
        stream_fifo_arbiter_pkt_cnt u_cnt (
            .clk   (ap_clk),
            .rst   (ap_rst),
            .inc   (pkt_done[i]),
            .count (pkt_cnt[i])
        );
    end

    // Guard against selects beyond NUM_SRC when NUM_SRC is not a power of 2.
    always_ff @(posedge ap_clk) begin
        if (ap_rst)
            stat_q <= '0;
        else
            stat_q <= (int'(stat_sel) < NUM_SRC) ? pkt_cnt[stat_sel] : '0;
    end
    assign stat_pkts = stat_q;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_pkts       = '0;
`endif

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
module tb_stream_fifo_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int P   = 16;
    localparam int CW  = 11;
    localparam int HWM = 1536;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  tdata;
    logic [N-1:0]    tvalid;
    logic [N-1:0]    tready;
    logic [W-1:0]    o_data;
    logic            o_valid;
    logic            o_ready;
    logic [1:0]      o_src;
    logic [CW-1:0]   fcnt;
    logic [N-1:0]    grant;
    logic            busy;
    logic [1:0]      sel;
    logic [15:0]     stat;

    always #5 clk = ~clk;

    stream_fifo_arbiter #(.NUM_SRC(N), .WIDTH(W), .PKT_LEN(P), .CNT_W(CW), .HIGH_WM(HWM)) dut (
        .ap_clk(clk), .ap_rst(rst),
        .in_V_TDATA(tdata), .in_V_TVALID(tvalid), .in_V_TREADY(tready),
        .out_V_TDATA(o_data), .out_V_TVALID(o_valid), .out_V_TREADY(o_ready),
        .out_src(o_src), .fifo_count(fcnt), .grant(grant), .busy(busy),
        .stat_sel(sel), .stat_pkts(stat)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The arbiter is described as "who owns the FIFO and how many beats it
    // has delivered"; owner -1 means nobody.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = N - 1;
    int m_src   = 0;
    int m_stats [N];
    int m_stat_q = 0;
    bit m_known = 0;
    int hs_cnt  = 0;

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            int s;
            s = (m_last + k) % N;
            if (tvalid[s]) return s;
        end
        return -1;
    endfunction

    task automatic compare_all();
        logic [31:0] eg, er;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        er = (m_owner >= 0 && o_ready) ? (32'd1 << m_owner) : 32'd0;
        chk("grant", grant, eg);
        chk("busy", busy, m_owner >= 0);
        chk("out_src", o_src, m_src);
        chk("out_valid", o_valid, (m_owner >= 0) ? tvalid[m_owner] : 1'b0);
        chk("in_ready", tready, er);
        if (m_owner >= 0 && tvalid[m_owner])
            chk("out_data", o_data, tdata[m_owner*W +: W]);
        chk("stat_pkts", stat, m_stat_q);
    endtask

    task automatic model_update();
        if (rst) begin
            m_owner = -1; m_beats = 0; m_last = N - 1; m_src = 0; m_stat_q = 0;
            foreach (m_stats[i]) m_stats[i] = 0;
            m_known = 1;
        end else begin
`ifdef STREAM_FIFO_ARB_STATS_EN
            m_stat_q = m_stats[sel];
`endif
            if (m_owner < 0) begin
                if (int'(fcnt) < HWM) begin
                    int p;
                    p = rr_pick();
                    if (p >= 0) begin m_owner = p; m_src = p; m_beats = 0; end
                end
            end else if (tvalid[m_owner] && o_ready) begin
                m_beats++;
                if (m_beats == P) begin
                    if (m_stats[m_owner] < 65535) m_stats[m_owner]++;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    endtask

    // Compare, clock once, then count handshakes per packet from the DUT's
    // own outputs: every packet that ends without reset must carry P beats.
    task automatic tick();
        logic hs, was_busy, r;
        #1;
        if (m_known) compare_all();
        hs = o_valid & o_ready; was_busy = busy; r = rst;
        @(posedge clk);
        model_update();
        #1;
        if (r) hs_cnt = 0;
        else begin
            if (hs) hs_cnt++;
            if (was_busy === 1'b1 && busy === 1'b0) begin
                chk("pkt_beats", hs_cnt, P);
                hs_cnt = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; tvalid = '0; o_ready = 1; fcnt = '0; sel = '0;
        tick();
        rst = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst;
        logic [N-1:0] vld;
        logic         rdy;
        int           cnt;
        logic [N-1:0] eg;
        logic         eb;
    } vec_t;
    vec_t vt[$];

    task automatic push(logic r, logic [N-1:0] v, logic rd, int c, logic [N-1:0] eg, logic eb);
        vec_t x;
        x.rst = r; x.vld = v; x.rdy = rd; x.cnt = c; x.eg = eg; x.eb = eb;
        vt.push_back(x);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1; tvalid = '0; tdata = '0; o_ready = 0; fcnt = '0; sel = '0;

        // Watermark / in-flight completion / reset-in-lock table.
        push(0, 4'hF, 1, 1536, 4'h0, 0);
        push(0, 4'hF, 1, 1536, 4'h0, 0);
        push(0, 4'hF, 1, 1535, 4'h0, 0);
        for (int i = 0; i < P; i++) push(0, 4'hF, 1, 1600, 4'h1, 1);
        push(0, 4'hF, 1, 1600, 4'h0, 0);
        push(0, 4'hF, 1, 1600, 4'h0, 0);
        push(0, 4'hF, 1, 1535, 4'h0, 0);
        push(1, 4'hF, 1, 1535, 4'h2, 1);
        push(0, 4'hF, 1, 1535, 4'h0, 0);
        push(0, 4'hF, 1, 1535, 4'h1, 1);

        do_reset();
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", o_valid, 0);
        chk("reset_in_ready", tready, 0);
        chk("reset_out_src", o_src, 0);
        chk("reset_stat", stat, 0);

        foreach (vt[i]) begin
            rst = vt[i].rst; tvalid = vt[i].vld; o_ready = vt[i].rdy;
            fcnt = CW'(vt[i].cnt); tdata = $urandom;
            #1;
            chk($sformatf("vec%0d_grant", i), grant, vt[i].eg);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].eb);
            tick();
        end

        // Single source: src1, continuous.
        do_reset();
        tvalid = 4'b0010; o_ready = 1;
        tick();
        chk("single_grant", grant, 4'b0010);
        for (int b = 0; b < P; b++) begin
            tdata = $urandom;
            #1;
            chk("single_beat_valid", o_valid, 1);
            chk("single_beat_src", o_src, 1);
            tick();
        end
        chk("single_end_grant", grant, 0);

        // Round-robin with all sources valid: 0,1,2,3,0, one idle per packet.
        do_reset();
        tvalid = 4'hF; o_ready = 1;
        for (int p = 0; p < 5; p++) begin
            chk("rr_idle", busy, 0);
            tick();
            chk($sformatf("rr_grant%0d", p), grant, 32'd1 << (p % N));
            for (int b = 0; b < P; b++) begin tdata = $urandom; tick(); end
        end

        // Reset mid-packet after 7 beats.
        do_reset();
        tvalid = 4'b0010; o_ready = 1;
        tick();
        for (int b = 0; b < 7; b++) begin tdata = $urandom; tick(); end
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("rstmid_grant", grant, 0);
        chk("rstmid_valid", o_valid, 0);
        chk("rstmid_ready", tready, 0);
        tvalid = 4'hF;
        tick();
        chk("rstmid_regrant", grant, 4'b0001);

`ifdef STREAM_FIFO_ARB_STATS_EN
        // Three packets from src2, then read counters back.
        do_reset();
        tvalid = 4'b0100; o_ready = 1;
        for (int c = 0; c < 3 * (P + 1); c++) tick();
        tvalid = '0; sel = 2;
        tick();
        chk("stat_src2", stat, 3);
        sel = 0;
        tick();
        chk("stat_src0", stat, 0);
        sel = 3;
        tick();
        chk("stat_src3", stat, 0);
`endif

        // Randomized traffic with backpressure, valid gaps, watermark
        // crossings and occasional reset, checked against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            tvalid  = N'($urandom);
            o_ready = ($urandom_range(0, 3) != 0);
            fcnt    = CW'($urandom_range(1500, 1600));
            tdata   = $urandom;
            sel     = 2'($urandom);
            rst     = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
